// File: rtl/serial_pkg.sv
// Shared types and constants for the serial clock generator / recovery pair.
package serial_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } serial_state_e;

  localparam int BYTE_W               = 8;
  localparam int DEFAULT_TIMEOUT_BITS = 8;

endpackage

// File: rtl/serial_sync.sv
// Synchronizer for one asynchronous line: SYNC_STAGES flops, the last of which becomes
// a glitch filter when SERIAL_CLOCK_RECOVERY_FILTER_EN is defined.
module serial_sync #(
  parameter int SYNC_STAGES = 2
`ifdef SERIAL_CLOCK_RECOVERY_FILTER_EN
  , parameter int FILTER_LEN = 3
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-2:0] r_sync;
  logic                   r_q;

  // Front metastability stages
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

`ifdef SERIAL_CLOCK_RECOVERY_FILTER_EN
  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [FCNT_W-1:0] r_run;

  // Final stage flips only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= 1'b0;
      r_run <= '0;
    end else if (r_sync[SYNC_STAGES-2] != r_q) begin
      if (r_run == FCNT_W'(FILTER_LEN - 1)) begin
        r_q   <= r_sync[SYNC_STAGES-2];
        r_run <= '0;
      end else begin
        r_run <= r_run + FCNT_W'(1);
      end
    end else begin
      r_run <= '0;
    end
  end
`else
  // Final plain synchronizer stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_sync[SYNC_STAGES-2];
    end
  end
`endif

  assign o_q = r_q;

endmodule

// File: rtl/serial_clock_recovery.sv
// Recovers sclk edge strobes and MSB-first bytes from an external serial clock/data pair.
// Optional glitch filter in the sync path: SERIAL_CLOCK_RECOVERY_FILTER_EN.
module serial_clock_recovery
  import serial_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS,
  parameter int FILTER_LEN   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclkIn,
  input  logic              sdIn,
  output logic              sclkPosEdge,
  output logic              sclkNegEdge,
  output logic              sclk8PosEdge,
  output logic [BYTE_W-1:0] rxByte,
  output logic              rxValid,
  output logic              framingErr,
  output logic              busy
);

`ifdef SERIAL_CLOCK_RECOVERY_FILTER_EN
  localparam int FILT_EXTRA = FILTER_LEN - 1;
`else
  localparam int FILT_EXTRA = 0 * FILTER_LEN;
`endif
  // Strobes stay masked until the sync path has flushed its reset value
  localparam int ARM_CYC = SYNC_STAGES + 1 + FILT_EXTRA;
  localparam int ARM_W   = $clog2(ARM_CYC + 1);
  localparam int CNT_W   = $clog2(BYTE_W);
  localparam logic [TIMEOUT_BITS-1:0] IDLE_MAX = {TIMEOUT_BITS{1'b1}};
  localparam logic [TIMEOUT_BITS-1:0] IDLE_PRE = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  logic w_sclk, w_sd, r_prev, w_armed, w_rise, w_fall;
  logic [ARM_W-1:0]        r_arm;
  serial_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_bit_cnt, w_cnt_nxt;
  logic [BYTE_W-2:0]       r_shift, w_shift_nxt;
  logic [BYTE_W-1:0]       w_shift_in, r_rx_byte, w_byte_nxt;
  logic [TIMEOUT_BITS-1:0] r_idle_cnt, w_idle_nxt;
  logic r_pos, r_neg, r_8pos, r_valid, r_ferr;
  logic w_pos_nxt, w_neg_nxt, w_8pos_nxt, w_valid_nxt, w_ferr_nxt;

  serial_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef SERIAL_CLOCK_RECOVERY_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_sync_sclk (
    .clk  (clk),
    .reset(reset),
    .i_d  (sclkIn),
    .o_q  (w_sclk)
  );

  serial_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef SERIAL_CLOCK_RECOVERY_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_sync_sd (
    .clk  (clk),
    .reset(reset),
    .i_d  (sdIn),
    .o_q  (w_sd)
  );

  assign w_armed    = (r_arm == ARM_W'(ARM_CYC));
  assign w_rise     = w_armed & w_sclk & ~r_prev;
  assign w_fall     = w_armed & ~w_sclk & r_prev;
  assign w_shift_in = {r_shift, w_sd};

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_byte_nxt  = r_rx_byte;
    w_idle_nxt  = r_idle_cnt;
    w_pos_nxt   = 1'b0;
    w_neg_nxt   = 1'b0;
    w_8pos_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    if (w_rise) begin
      w_pos_nxt   = 1'b1;
      w_idle_nxt  = '0;
      w_shift_nxt = w_shift_in[BYTE_W-2:0];
      w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
      w_state_nxt = RECV;
      w_8pos_nxt  = (r_bit_cnt == CNT_W'(0));
      if (r_bit_cnt == CNT_W'(BYTE_W - 1)) begin
        w_byte_nxt  = w_shift_in;
        w_valid_nxt = 1'b1;
      end else begin
        w_byte_nxt  = r_rx_byte;
      end
    end else if (w_fall) begin
      w_neg_nxt  = 1'b1;
      w_idle_nxt = '0;
    end else begin
      if (r_idle_cnt != IDLE_MAX) begin
        w_idle_nxt = r_idle_cnt + TIMEOUT_BITS'(1);
      end else begin
        w_idle_nxt = r_idle_cnt;
      end
      case (r_state)
        RECV: begin
          if (r_idle_cnt == IDLE_PRE) begin
            w_state_nxt = IDLE;
            if (r_bit_cnt != CNT_W'(0)) begin
              w_ferr_nxt  = 1'b1;
              w_cnt_nxt   = '0;
              w_shift_nxt = '0;
            end else begin
              w_ferr_nxt  = 1'b0;
            end
          end else begin
            w_state_nxt = RECV;
          end
        end
        IDLE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_idle_cnt <= '0;
      r_prev     <= 1'b0;
      r_arm      <= '0;
      r_pos      <= 1'b0;
      r_neg      <= 1'b0;
      r_8pos     <= 1'b0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_byte  <= w_byte_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_prev     <= w_sclk;
      r_arm      <= w_armed ? r_arm : r_arm + ARM_W'(1);
      r_pos      <= w_pos_nxt;
      r_neg      <= w_neg_nxt;
      r_8pos     <= w_8pos_nxt;
      r_valid    <= w_valid_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  assign sclkPosEdge  = r_pos;
  assign sclkNegEdge  = r_neg;
  assign sclk8PosEdge = r_8pos;
  assign rxByte       = r_rx_byte;
  assign rxValid      = r_valid;
  assign framingErr   = r_ferr;
  assign busy         = (r_state == RECV);

endmodule

// File: doc/serial_clock_recovery.md
# serial_clock_recovery

- Receive-side counterpart of the serial clock generator: takes an externally driven serial clock and data line into the `clk` domain.
- Detects sclk rising and falling edges and emits the same single-cycle strobes the generator produces: `sclkPosEdge`, `sclkNegEdge`, `sclk8PosEdge`.
- Deserializes MSB-first bytes, sampling data on sclk rising edges.
- Flags bytes abandoned mid-transfer via an idle timeout.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchronizer depth for `sclkIn`/`sdIn` (≥2)
- `TIMEOUT_BITS`, 8, idle timeout = 2**TIMEOUT_BITS-1 `clk` cycles without a synchronized sclk edge
- `FILTER_LEN`, 3, consecutive equal samples required by the glitch filter (only with macro)

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `sclkIn` in 1: asynchronous serial clock
- `sdIn` in 1: asynchronous serial data
- `sclkPosEdge` out 1: one-cycle strobe per accepted sclk rising edge
- `sclkNegEdge` out 1: one-cycle strobe per accepted sclk falling edge
- `sclk8PosEdge` out 1: one-cycle strobe on the rising edge that carries bit 0 (first bit) of a byte
- `rxByte` out 8: last completed byte, held until the next completion
- `rxValid` out 1: one-cycle strobe when `rxByte` updates
- `framingErr` out 1: one-cycle strobe when a partial byte is discarded by timeout
- `busy` out 1: high while in RECV

## Operation
- `sclkIn` and `sdIn` pass through identical sync paths, so they remain aligned.
- Edge detection compares the synchronized sclk level with its previous value.
- Reset: all outputs 0; state IDLE; bit counter 0; shift register 0; idle counter 0; sync flops 0.
- Arm window: strobes and state changes are suppressed for SYNC_STAGES+1 cycles after reset deasserts.
  - The previous-level register still tracks the synchronized level during this window.
  - A high `sclkIn` at reset release therefore produces no spurious rising edge.
- State machine, two states:
  - **IDLE**: a rising edge shifts in `sdIn`, sets bit counter to 1, pulses `sclk8PosEdge`, and moves to RECV. Falling edges pulse `sclkNegEdge` only.
  - **RECV**: each rising edge shifts the sample into bit 0 (MSB first) and increments the 3-bit counter.
    - If the counter equals 0 before the edge, `sclk8PosEdge` also pulses.
    - On the 8th bit (counter wraps 7→0), `rxByte` takes the completed shift value and `rxValid` pulses.
    - The state stays RECV.
- Idle counter:
  - Clears on any accepted edge; otherwise increments, saturating.
  - On reaching the timeout in RECV with counter ≠ 0: pulse `framingErr`, clear counter and shift register, go to IDLE.
  - On timeout with counter = 0: go to IDLE silently.
- Simultaneous edge and timeout in the same cycle: the edge wins and no timeout occurs.
- Reset mid-byte: the partial byte is discarded; no `framingErr` or `rxValid`.
- `rxByte` is never modified by timeout.

## Timing
- Latency is SYNC_STAGES+1 `clk` cycles.
  - Measured from the first `clk` edge that samples a new `sclkIn` level to the cycle the strobe is high.
  - Default is 3 cycles.
- `rxValid` and the new `rxByte` appear in the same cycle as the 8th `sclkPosEdge`.
- All strobes are exactly one cycle wide.
- `sclkPosEdge` and `sclkNegEdge` are never high together.
- Minimum supported sclk half-period is SYNC_STAGES+1 `clk` cycles; shorter pulses may be lost.
- Default timeout (255 cycles) exceeds the generator's sclk half-period of 31 cycles.

## Configuration
- `SERIAL_CLOCK_RECOVERY_FILTER_EN`
  - Defined: the sync path adds a glitch filter. The filtered level changes only after FILTER_LEN consecutive synchronized samples all differ from the current level. Pulses shorter than FILTER_LEN cycles are rejected. Latency grows by FILTER_LEN-1 cycles, as do the arm window and the minimum half-period.
  - Undefined: filtered level equals synchronized level; FILTER_LEN is ignored.

## Structure
- Package `serial_pkg` holds:
  - state enum (IDLE, RECV)
  - `BYTE_W` = 8
  - default timeout width
- These are shared with the generator side.
- Sub-module `serial_sync`: SYNC_STAGES flops plus the optional filter, with reset to 0. It is instantiated once for `sclkIn` and once for `sdIn`; the same module keeps their latency equal.

## Test plan
- Byte 0xA5 driven MSB first, half-period 31 `clk` → `rxByte`=0xA5 and one `rxValid` on the 8th `sclkPosEdge`; `sclk8PosEdge` only on the 1st rising edge; 8 `sclkNegEdge` strobes.
- Bytes 0x3C then 0xFF back-to-back → two `rxValid`; `sclk8PosEdge` on edges 1 and 9; `busy` stays 1 until 255 idle cycles after the last edge.
- 3 bits of a byte, then sclk held low for 300 cycles → `framingErr` pulses once at idle count 255; `rxByte` unchanged; `busy`=0.
- `sclkIn` held high through reset release → no `sclkPosEdge`; the first strobe is `sclkNegEdge` on the later falling edge.
- Assert `reset` after 5 bits, then send 0x81 → no `framingErr`; `rxByte`=0x81.
- With the FILTER macro defined: a 2-cycle sclk glitch → no strobes; a clean edge → strobe after SYNC_STAGES+FILTER_LEN = 5 cycles.
